regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback sources: requester 0 (ALU result) and requester 1 (load data from data memory). It uses round-robin arbitration over a valid/ready handshake. It also keeps a per-register pending scoreboard, which the issue stage uses to stall on read-after-write hazards. It sits between the execute/memory stages and the register file, directly driving its rd_we, writeReg and writeData inputs.

---
 rtl/regfile_wb_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter for the register-file write port with pending-write scoreboard
module regfile_wb_arbiter #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wb0_valid,
   input  logic [4:0]       wb0_rd,
   input  logic [XLEN-1:0]  wb0_data,
   output logic             wb0_ready,
   input  logic             wb1_valid,
   input  logic [4:0]       wb1_rd,
   input  logic [XLEN-1:0]  wb1_data,
   output logic             wb1_ready,
   input  logic             alloc_valid,
   input  logic [4:0]       alloc_rd,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   output logic             hazard,
   output logic             rd_we,
   output logic [4:0]       writeReg,
   output logic [XLEN-1:0]  writeData,
   output logic [31:0]      pending,
   output logic [CNT_W-1:0] conflict_cnt
);

   // rr_ptr: 0 = requester 0 wins the next contended cycle, 1 = requester 1 wins
   logic             rr_ptr_q, rr_ptr_d;
   logic [31:0]      pending_q, pending_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             both;
   logic             gnt0, gnt1;
   logic [4:0]       sel_rd;
   logic [XLEN-1:0]  sel_data;

   // Grant selection; nothing is granted while reset is held
   always_comb begin
      both = wb0_valid & wb1_valid;
      gnt0 = ~rst & wb0_valid & (~wb1_valid | ~rr_ptr_q);
      gnt1 = ~rst & wb1_valid & (~wb0_valid |  rr_ptr_q);
      wb0_ready = gnt0;
      wb1_ready = gnt1;
   end

   // Route the granted request to the register-file write port; writes to x0 are consumed but not performed
   always_comb begin
      sel_rd   = 5'd0;
      sel_data = '0;
      if (gnt0) begin
         sel_rd   = wb0_rd;
         sel_data = wb0_data;
      end else if (gnt1) begin
         sel_rd   = wb1_rd;
         sel_data = wb1_data;
      end
      rd_we     = (gnt0 | gnt1) & (sel_rd != 5'd0);
      writeReg  = rd_we ? sel_rd : 5'd0;
      writeData = rd_we ? sel_data : '0;
   end

   // Next-state: pointer moves to the loser of a contended cycle; alloc beats a same-cycle clear
   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      pending_d = pending_q;
      cnt_d     = cnt_q;
      if (both) begin
         rr_ptr_d = gnt0;
         if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      if (rd_we) begin
         pending_d[writeReg] = 1'b0;
      end
      if (alloc_valid && (alloc_rd != 5'd0)) begin
         pending_d[alloc_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
      if (rst) begin
         rr_ptr_d  = 1'b0;
         pending_d = '0;
         cnt_d     = '0;
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
   end

   // RAW hazard from the registered scoreboard only; no bypass from the write port
   always_comb begin
      hazard = ~rst & (((rs1 != 5'd0) & pending_q[rs1]) | ((rs2 != 5'd0) & pending_q[rs2]));
   end

   assign pending      = pending_q;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             wb0_valid, wb1_valid;
   logic [4:0]       wb0_rd, wb1_rd;
   logic [XLEN-1:0]  wb0_data, wb1_data;
   logic             wb0_ready, wb1_ready;
   logic             alloc_valid;
   logic [4:0]       alloc_rd, rs1, rs2;
   logic             hazard, rd_we;
   logic [4:0]       writeReg;
   logic [XLEN-1:0]  writeData;
   logic [31:0]      pending;
   logic [CNT_W-1:0] conflict_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   regfile_wb_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
      .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .rs1(rs1), .rs2(rs2),
      .hazard(hazard), .rd_we(rd_we), .writeReg(writeReg), .writeData(writeData),
      .pending(pending), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v0;
      logic [4:0]  rd0;
      logic [31:0] d0;
      logic        v1;
      logic [4:0]  rd1;
      logic [31:0] d1;
      logic        er0;
      logic        er1;
      logic        ewe;
      logic [4:0]  ewr;
      logic [31:0] ewd;
      logic [3:0]  ecnt;
      logic        err;
   } vec_t;

   vec_t vecs[8];
   vec_t exp_q[$];

   function automatic vec_t mk(logic v0, logic [4:0] rd0, logic [31:0] d0,
                               logic v1, logic [4:0] rd1, logic [31:0] d1,
                               logic er0, logic er1, logic ewe, logic [4:0] ewr,
                               logic [31:0] ewd, logic [3:0] ecnt, logic err);
      vec_t v;
      v.v0 = v0; v.rd0 = rd0; v.d0 = d0; v.v1 = v1; v.rd1 = rd1; v.d1 = d1;
      v.er0 = er0; v.er1 = er1; v.ewe = ewe; v.ewr = ewr; v.ewd = ewd;
      v.ecnt = ecnt; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_idle();
      wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
      wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
      alloc_valid = 0; alloc_rd = 0; rs1 = 0; rs2 = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t e;
      // single ALU write, single load write, 4 contended cycles from rr_ptr=0, x0 write, idle
      vecs[0] = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        1, 0, 1, 5'd5,  32'hDEADBEEF, 4'd0, 1'b0);
      vecs[1] = mk(0, 5'd0,  32'h0,        1, 5'd6,  32'h00001234, 0, 1, 1, 5'd6,  32'h00001234, 4'd0, 1'b0);
      vecs[2] = mk(1, 5'd10, 32'hA0A0A0A0, 1, 5'd11, 32'hB1B1B1B1, 1, 0, 1, 5'd10, 32'hA0A0A0A0, 4'd0, 1'b0);
      vecs[3] = mk(1, 5'd10, 32'hA0A0A0A0, 1, 5'd11, 32'hB1B1B1B1, 0, 1, 1, 5'd11, 32'hB1B1B1B1, 4'd1, 1'b1);
      vecs[4] = mk(1, 5'd12, 32'hC2C2C2C2, 1, 5'd11, 32'hB1B1B1B1, 1, 0, 1, 5'd12, 32'hC2C2C2C2, 4'd2, 1'b0);
      vecs[5] = mk(1, 5'd13, 32'hD3D3D3D3, 1, 5'd11, 32'hB1B1B1B1, 0, 1, 1, 5'd11, 32'hB1B1B1B1, 4'd3, 1'b1);
      vecs[6] = mk(1, 5'd0,  32'hFFFFFFFF, 0, 5'd0,  32'h0,        1, 0, 0, 5'd0,  32'h0,        4'd4, 1'b0);
      vecs[7] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 5'd0,  32'h0,        4'd4, 1'b0);

      // reset with active inputs: everything must stay quiet
      set_idle();
      rst = 1;
      wb0_valid = 1; wb0_rd = 5'd5; wb1_valid = 1; wb1_rd = 5'd6;
      alloc_valid = 1; alloc_rd = 5'd4; rs1 = 5'd4;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("rst_ready0", wb0_ready, 0);
      chk("rst_ready1", wb1_ready, 0);
      chk("rst_rd_we", rd_we, 0);
      chk("rst_hazard", hazard, 0);
      chk("rst_writeReg", writeReg, 0);
      chk("rst_writeData", writeData, 0);
      chk("rst_pending", pending, 0);
      chk("rst_cnt", conflict_cnt, 0);
      @(posedge clk);
      #1;
      rst = 0;
      set_idle();

      // table-driven vectors through the expected-output queue
      for (int i = 0; i < 8; i++) begin
         cyc();
         wb0_valid = vecs[i].v0; wb0_rd = vecs[i].rd0; wb0_data = vecs[i].d0;
         wb1_valid = vecs[i].v1; wb1_rd = vecs[i].rd1; wb1_data = vecs[i].d1;
         exp_q.push_back(vecs[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         chk($sformatf("v%0d_ready0", i), wb0_ready, e.er0);
         chk($sformatf("v%0d_ready1", i), wb1_ready, e.er1);
         chk($sformatf("v%0d_rd_we", i), rd_we, e.ewe);
         chk($sformatf("v%0d_writeReg", i), writeReg, e.ewr);
         chk($sformatf("v%0d_writeData", i), writeData, e.ewd);
         chk($sformatf("v%0d_cnt", i), conflict_cnt, e.ecnt);
         chk($sformatf("v%0d_rr_ptr", i), dut.rr_ptr_q, e.err);
      end

      // alloc x7 then hazard; wb1 write clears one cycle later
      cyc(); set_idle(); alloc_valid = 1; alloc_rd = 5'd7;
      cyc(); set_idle(); rs1 = 5'd7;
      @(negedge clk);
      chk("haz_set", hazard, 1);
      chk("haz_pend7", pending[7], 1);
      cyc(); wb1_valid = 1; wb1_rd = 5'd7; wb1_data = 32'h77777777;
      @(negedge clk);
      chk("haz_wr_ready1", wb1_ready, 1);
      chk("haz_wr_we", rd_we, 1);
      chk("haz_no_bypass", hazard, 1);
      cyc(); wb1_valid = 0; rs2 = 5'd7; rs1 = 5'd0;
      @(negedge clk);
      chk("haz_clear", hazard, 0);
      chk("haz_pend7_clr", pending[7], 0);

      // same-cycle alloc and write of x9: set wins
      cyc(); set_idle(); alloc_valid = 1; alloc_rd = 5'd9;
      cyc(); wb0_valid = 1; wb0_rd = 5'd9; wb0_data = 32'h99999999;
      @(negedge clk);
      chk("sw_ready0", wb0_ready, 1);
      cyc(); set_idle(); rs1 = 5'd9;
      @(negedge clk);
      chk("sw_pend9", pending[9], 1);
      chk("sw_hazard", hazard, 1);
      cyc(); set_idle(); wb0_valid = 1; wb0_rd = 5'd9; wb0_data = 32'h1;
      cyc(); set_idle();
      @(negedge clk);
      chk("sw_pend9_clr", pending[9], 0);

      // x0 is never tracked
      cyc(); set_idle(); alloc_valid = 1; alloc_rd = 5'd0;
      cyc(); set_idle(); rs1 = 5'd0; rs2 = 5'd0;
      @(negedge clk);
      chk("x0_pend0", pending[0], 0);
      chk("x0_hazard", hazard, 0);

      // build state, then reset mid-operation
      cyc(); set_idle(); alloc_valid = 1; alloc_rd = 5'd3;
      cyc(); set_idle(); alloc_valid = 1; alloc_rd = 5'd12;
      cyc(); set_idle(); wb0_valid = 1; wb0_rd = 5'd1; wb1_valid = 1; wb1_rd = 5'd2;
      @(negedge clk);
      chk("pre_rst_grant0", wb0_ready, 1);
      cyc(); set_idle();
      @(negedge clk);
      chk("pre_rst_pending", pending, 32'h00001008);
      chk("pre_rst_rr", dut.rr_ptr_q, 1);
      cyc(); rst = 1; wb0_valid = 1; wb0_rd = 5'd4; wb0_data = 32'h44;
      alloc_valid = 1; alloc_rd = 5'd5; rs1 = 5'd3;
      @(negedge clk);
      chk("mid_rst_ready0", wb0_ready, 0);
      chk("mid_rst_we", rd_we, 0);
      chk("mid_rst_hazard", hazard, 0);
      cyc(); rst = 0; alloc_valid = 0; alloc_rd = 0;
      @(negedge clk);
      chk("post_rst_pending", pending, 0);
      chk("post_rst_rr", dut.rr_ptr_q, 0);
      chk("post_rst_cnt", conflict_cnt, 0);
      chk("post_rst_ready0", wb0_ready, 1);
      chk("post_rst_writeReg", writeReg, 5'd4);
      chk("post_rst_hazard", hazard, 0);

      // sustained contention: alternating grants, counter saturates
      cyc(); set_idle(); wb0_valid = 1; wb0_rd = 5'd1; wb1_valid = 1; wb1_rd = 5'd2;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk($sformatf("sat_grant_%0d", k), {wb0_ready, wb1_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
         cyc();
      end
      @(negedge clk);
      chk("sat_cnt", conflict_cnt, 4'hF);
      cyc();
      @(negedge clk);
      chk("sat_cnt_hold", conflict_cnt, 4'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
